aclock_setter: RTL and testbench

//  Button-driven front end that writes time and alarm values into aclock. It converts

---
 rtl/aclock_setter_if.sv | 33 +++
 rtl/aclock_setter.sv | 231 +++++++++++++++++++++++
 tb/tb_aclock_setter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/aclock_setter_if.sv
// Panel-side bundle for aclock_setter: buttons, current time
// read back from aclock, and the digit/strobe outputs to aclock.
interface aclock_setter_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_sel;
    logic [1:0] H_cur1;
    logic [3:0] H_cur0;
    logic [3:0] M_cur1;
    logic [3:0] M_cur0;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       editing;
    logic       field;

    modport master (
        output btn_mode, btn_inc, btn_sel,
        output H_cur1, H_cur0, M_cur1, M_cur0,
        input  H_in1, H_in0, M_in1, M_in0,
        input  LD_time, LD_alarm, editing, field
    );

    modport slave (
        input  btn_mode, btn_inc, btn_sel,
        input  H_cur1, H_cur0, M_cur1, M_cur0,
        output H_in1, H_in0, M_in1, M_in0,
        output LD_time, LD_alarm, editing, field
    );
endinterface

// File: rtl/aclock_setter.sv
// Button-driven HH:MM editor that loads time or alarm into aclock.
// Mode steps IDLE -> hours -> minutes -> load; inc bumps the field.
module aclock_setter #(
    parameter int LD_HOLD      = 1,
    parameter int EDIT_TIMEOUT = 100,
    parameter int REPEAT_DLY   = 5,
    parameter int REPEAT_RATE  = 2
) (
    input  logic           clk,
    input  logic           reset,
    aclock_setter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        EDIT_HR,
        EDIT_MIN,
        LOAD
    } state_t;

    state_t      state;
    state_t      state_n;

    logic        mode_q;
    logic        inc_q;
    logic        target;

    logic [1:0]  h1;
    logic [3:0]  h0;
    logic [3:0]  m1;
    logic [3:0]  m0;
    logic [1:0]  sh1;
    logic [3:0]  sh0;
    logic [3:0]  sm1;
    logic [3:0]  sm0;

    logic [15:0] hold_cnt;
    logic [15:0] rate_cnt;
    logic        rep_on;
    logic [15:0] to_cnt;
    logic [15:0] ld_cnt;

    logic        mode_ev;
    logic        inc_edge;
    logic        held;
    logic        rep_hit;
    logic        inc_any;
    logic        evt;
    logic        timeout;
    logic        ld_done;
    logic        in_edit;

    logic        do_pre;
    logic        do_inc_h;
    logic        do_inc_m;
    logic        do_shadow;

    logic [1:0]  pre_h1;
    logic [3:0]  pre_h0;
    logic [3:0]  pre_m1;
    logic [3:0]  pre_m0;
    logic        pre_bad;

    assign mode_ev  = bus.btn_mode & ~mode_q;
    assign inc_edge = bus.btn_inc & ~inc_q;
    assign held     = bus.btn_inc & inc_q;

    assign rep_hit = (REPEAT_DLY != 0) && held &&
                     (rep_on ? (rate_cnt == 16'(REPEAT_RATE))
                             : (hold_cnt == 16'(REPEAT_DLY)));

    assign inc_any = (inc_edge | rep_hit) & ~mode_ev;
    assign evt     = mode_ev | inc_any;
    assign timeout = to_cnt == 16'(EDIT_TIMEOUT - 1);
    assign ld_done = ld_cnt == 16'(LD_HOLD - 1);
    assign in_edit = (state == EDIT_HR) || (state == EDIT_MIN);

    assign pre_h1 = bus.btn_sel ? sh1 : bus.H_cur1;
    assign pre_h0 = bus.btn_sel ? sh0 : bus.H_cur0;
    assign pre_m1 = bus.btn_sel ? sm1 : bus.M_cur1;
    assign pre_m0 = bus.btn_sel ? sm0 : bus.M_cur0;

    assign pre_bad = (pre_h0 > 4'd9) || (pre_m1 > 4'd5) ||
                     (pre_m0 > 4'd9) || (pre_h1 == 2'd3) ||
                     ((pre_h1 == 2'd2) && (pre_h0 > 4'd3));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next state and per-cycle digit/shadow actions.
    always_comb begin
        state_n   = state;
        do_pre    = 1'b0;
        do_inc_h  = 1'b0;
        do_inc_m  = 1'b0;
        do_shadow = 1'b0;
        unique case (state)
            IDLE: begin
                if (mode_ev) begin
                    state_n = EDIT_HR;
                    do_pre  = 1'b1;
                end
            end
            EDIT_HR: begin
                if (mode_ev)      state_n  = EDIT_MIN;
                else if (inc_any) do_inc_h = 1'b1;
                else if (timeout) state_n  = IDLE;
            end
            EDIT_MIN: begin
                if (mode_ev)      state_n  = LOAD;
                else if (inc_any) do_inc_m = 1'b1;
                else if (timeout) state_n  = IDLE;
            end
            LOAD: begin
                if (ld_done) begin
                    state_n   = IDLE;
                    do_shadow = target;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Button history, target latch, timeout and load counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= 1'b0;
            inc_q  <= 1'b0;
            target <= 1'b0;
            to_cnt <= '0;
            ld_cnt <= '0;
        end else begin
            mode_q <= bus.btn_mode;
            inc_q  <= bus.btn_inc;
            if (do_pre) target <= bus.btn_sel;
            if ((state_n != state) || evt) to_cnt <= '0;
            else if (in_edit)              to_cnt <= to_cnt + 16'd1;
            if ((state == LOAD) && !ld_done) ld_cnt <= ld_cnt + 16'd1;
            else                             ld_cnt <= '0;
        end
    end

    // Auto-repeat timing while btn_inc stays held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
            rate_cnt <= '0;
            rep_on   <= 1'b0;
        end else if (inc_edge) begin
            hold_cnt <= 16'd1;
            rate_cnt <= '0;
            rep_on   <= 1'b0;
        end else if (held) begin
            if (rep_on) begin
                rate_cnt <= rep_hit ? 16'd1 : rate_cnt + 16'd1;
            end else if (hold_cnt == 16'(REPEAT_DLY)) begin
                rep_on   <= 1'b1;
                rate_cnt <= 16'd1;
            end else begin
                hold_cnt <= hold_cnt + 16'd1;
            end
        end else begin
            hold_cnt <= '0;
            rate_cnt <= '0;
            rep_on   <= 1'b0;
        end
    end

    // Edited digits: preload on entry, BCD increments while editing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h1 <= '0;
            h0 <= '0;
            m1 <= '0;
            m0 <= '0;
        end else if (do_pre) begin
            h1 <= pre_bad ? 2'd0 : pre_h1;
            h0 <= pre_bad ? 4'd0 : pre_h0;
            m1 <= pre_bad ? 4'd0 : pre_m1;
            m0 <= pre_bad ? 4'd0 : pre_m0;
        end else if (do_inc_h) begin
            if ((h1 == 2'd2) && (h0 == 4'd3)) begin
                h1 <= 2'd0;
                h0 <= 4'd0;
            end else if (h0 == 4'd9) begin
                h1 <= h1 + 2'd1;
                h0 <= 4'd0;
            end else begin
                h0 <= h0 + 4'd1;
            end
        end else if (do_inc_m) begin
            if ((m1 == 4'd5) && (m0 == 4'd9)) begin
                m1 <= 4'd0;
                m0 <= 4'd0;
            end else if (m0 == 4'd9) begin
                m1 <= m1 + 4'd1;
                m0 <= 4'd0;
            end else begin
                m0 <= m0 + 4'd1;
            end
        end
    end

    // Alarm shadow, written when an alarm load completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh1 <= '0;
            sh0 <= '0;
            sm1 <= '0;
            sm0 <= '0;
        end else if (do_shadow) begin
            sh1 <= h1;
            sh0 <= h0;
            sm1 <= m1;
            sm0 <= m0;
        end
    end

    assign bus.H_in1    = h1;
    assign bus.H_in0    = h0;
    assign bus.M_in1    = m1;
    assign bus.M_in0    = m0;
    assign bus.LD_time  = (state == LOAD) && !target;
    assign bus.LD_alarm = (state == LOAD) && target;
    assign bus.editing  = in_edit;
    assign bus.field    = state == EDIT_MIN;

endmodule

// File: tb/tb_aclock_setter.sv
// Self-checking bench for aclock_setter: scoreboarded load strobes
// plus direct digit, timeout, auto-repeat and async-reset checks.
module tb_aclock_setter;

    logic clk = 1'b0;
    logic rst1;
    logic rst2;

    always #5 clk = ~clk;

    aclock_setter_if if1 ();
    aclock_setter_if if2 ();

    aclock_setter #(
        .LD_HOLD(1), .EDIT_TIMEOUT(100),
        .REPEAT_DLY(5), .REPEAT_RATE(2)
    ) u1 (.clk(clk), .reset(rst1), .bus(if1));

    aclock_setter #(
        .LD_HOLD(3), .EDIT_TIMEOUT(100),
        .REPEAT_DLY(5), .REPEAT_RATE(2)
    ) u2 (.clk(clk), .reset(rst2), .bus(if2));

    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] sbq[$];
    logic [15:0] mon_got;
    logic [15:0] tmp;
    int          eh;
    int          em;
    bit          efield;
    int          n;
    int          lt_seen;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pack(bit t, bit a, int h, int m);
        return {t, a, 2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic chk_digits(string tag);
        logic [15:0] p;
        p = pack(1'b0, 1'b0, eh, em);
        chk(tag, {18'd0, if1.H_in1, if1.H_in0, if1.M_in1, if1.M_in0},
            {18'd0, p[13:0]});
    endtask

    task automatic set_cur(int h, int m);
        if1.H_cur1 = 2'(h / 10);
        if1.H_cur0 = 4'(h % 10);
        if1.M_cur1 = 4'(m / 10);
        if1.M_cur0 = 4'(m % 10);
    endtask

    task automatic press_mode();
        @(negedge clk); if1.btn_mode = 1'b1;
        @(negedge clk); if1.btn_mode = 1'b0;
    endtask

    task automatic press_inc(int cnt);
        repeat (cnt) begin
            @(negedge clk); if1.btn_inc = 1'b1;
            @(negedge clk); if1.btn_inc = 1'b0;
            if (efield) em = (em + 1) % 60;
            else        eh = (eh + 1) % 24;
        end
    endtask

    task automatic enter(bit sel, int ph, int pm);
        if1.btn_sel = sel;
        press_mode();
        eh = ph; em = pm; efield = 1'b0;
    endtask

    task automatic commit(bit sel);
        sbq.push_back(pack(!sel, sel, eh, em));
        press_mode();
        repeat (2) @(negedge clk);
    endtask

    task automatic p2(bit md);
        @(negedge clk);
        if (md) if2.btn_mode = 1'b1; else if2.btn_inc = 1'b1;
        @(negedge clk);
        if2.btn_mode = 1'b0; if2.btn_inc = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst1 && (if1.LD_time || if1.LD_alarm)) begin
            mon_got = {if1.LD_time, if1.LD_alarm, if1.H_in1,
                       if1.H_in0, if1.M_in1, if1.M_in0};
            if (sbq.size() == 0) chk("ld_unexpected", 32'(mon_got), 32'd0);
            else                 chk("ld_commit", 32'(mon_got), 32'(sbq.pop_front()));
        end
    end

    initial begin
        rst1 = 1'b0; rst2 = 1'b0;
        if1.btn_mode = 0; if1.btn_inc = 0; if1.btn_sel = 0;
        if2.btn_mode = 0; if2.btn_inc = 0; if2.btn_sel = 0;
        set_cur(0, 0);
        if2.H_cur1 = 0; if2.H_cur0 = 0; if2.M_cur1 = 0; if2.M_cur0 = 0;
        eh = 0; em = 0; efield = 0;
        #3;
        chk("rst_state", {if1.LD_time, if1.LD_alarm, if1.editing, if1.field},
            4'b0000);
        chk_digits("rst_digits");
        @(negedge clk); rst1 = 1'b1; rst2 = 1'b1;

        enter(1'b0, 0, 0);
        chk("enter_edit", {if1.editing, if1.field}, 2'b10);
        chk_digits("pre_zero");
        press_inc(12);
        chk_digits("hr_12");
        press_mode(); efield = 1'b1;
        chk("field_min", {if1.editing, if1.field}, 2'b11);
        press_inc(34);
        chk_digits("min_34");
        commit(1'b0);
        chk("idle_after_ld", if1.editing, 1'b0);

        set_cur(23, 59);
        enter(1'b0, 23, 59);
        chk_digits("pre_2359");
        press_inc(1);
        chk_digits("hr_wrap");
        press_mode(); efield = 1'b1;
        press_inc(1);
        chk_digits("min_wrap_nocarry");
        commit(1'b0);

        set_cur(7, 7);
        enter(1'b1, 0, 0);
        chk_digits("pre_shadow0");
        press_inc(12);
        press_mode(); efield = 1'b1;
        press_inc(35);
        commit(1'b1);
        enter(1'b1, 12, 35);
        chk_digits("pre_shadow_1235");
        repeat (90) @(negedge clk);
        chk("still_editing", if1.editing, 1'b1);
        repeat (15) @(negedge clk);
        chk("timeout_idle", if1.editing, 1'b0);
        chk_digits("timeout_keep");

        set_cur(10, 20);
        enter(1'b0, 10, 20);
        chk_digits("pre_1020");
        @(negedge clk); if1.btn_mode = 1'b1; if1.btn_inc = 1'b1;
        @(negedge clk); if1.btn_mode = 1'b0; if1.btn_inc = 1'b0;
        efield = 1'b1;
        chk("same_cyc_field", if1.field, 1'b1);
        chk_digits("same_cyc_noinc");
        press_inc(1);
        chk_digits("min_21");
        commit(1'b0);

        set_cur(24, 0);
        enter(1'b0, 0, 0);
        chk_digits("pre_bad_hr");
        press_mode(); efield = 1'b1;
        commit(1'b0);
        if1.H_cur1 = 2'd1; if1.H_cur0 = 4'd2; if1.M_cur1 = 4'd3; if1.M_cur0 = 4'd12;
        enter(1'b0, 0, 0);
        chk_digits("pre_bad_digit");

        @(negedge clk); if1.btn_inc = 1'b1;
        repeat (11) @(negedge clk);
        if1.btn_inc = 1'b0;
        eh = 4;
        chk_digits("auto_repeat");
        press_mode(); efield = 1'b1;
        commit(1'b0);

        set_cur(0, 0);
        enter(1'b0, 0, 0);
        press_inc(3);
        #2 rst1 = 1'b0;
        #1;
        eh = 0; em = 0;
        chk("async_rst", {if1.LD_time, if1.LD_alarm, if1.editing, if1.field},
            4'b0000);
        chk_digits("async_rst_digits");
        @(negedge clk); rst1 = 1'b1;

        if2.btn_sel = 1'b1;
        p2(1); p2(0); p2(1); p2(1);
        chk("ld3_first", {if2.LD_alarm, if2.LD_time}, 2'b10);
        @(negedge clk);
        chk("ld3_second", {if2.LD_alarm, if2.LD_time}, 2'b10);
        #2 rst2 = 1'b0;
        #1;
        chk("ld3_rst_drop", {if2.LD_alarm, if2.LD_time, if2.editing}, 3'b000);
        @(negedge clk); rst2 = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (if2.LD_alarm || if2.LD_time || if2.editing) n++;
        end
        chk("ld3_idle_after", n, 0);
        p2(1);
        tmp = {2'b00, if2.H_in1, if2.H_in0, if2.M_in1, if2.M_in0};
        chk("ld3_shadow_clr", {if2.editing, tmp}, {1'b1, 16'd0});
        p2(1); p2(1);
        n = 0; lt_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (if2.LD_alarm) n++;
            if (if2.LD_time) lt_seen++;
            @(negedge clk);
        end
        chk("ld3_hold_len", n, 3);
        chk("ld3_no_time", lt_seen, 0);

        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
